// File: rtl/branch_unit.sv
// Branch decision unit for the single-cycle RV32I execute stage.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      BrOp,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            NextPCSrc,
    output logic            BrIllegal,
    output logic            NextPCSrc_q
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] TakenCount
`endif
);

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    logic isEq;
    logic isLtSigned;
    logic isLtUnsigned;
    logic isCondBranch;

    assign isEq         = (A == B);
    assign isLtSigned   = ($signed(A) < $signed(B));
    assign isLtUnsigned = (A < B);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        NextPCSrc    = 1'b0;
        BrIllegal    = 1'b0;
        isCondBranch = 1'b0;
        if (BrOp[4]) begin
            NextPCSrc = 1'b1;
        end else if (BrOp[3]) begin
            isCondBranch = 1'b1;
            case (BrOp[2:0])
                BEQ:     NextPCSrc = isEq;
                BNE:     NextPCSrc = !isEq;
                BLT:     NextPCSrc = isLtSigned;
                BGE:     NextPCSrc = !isLtSigned;
                BLTU:    NextPCSrc = isLtUnsigned;
                BGEU:    NextPCSrc = !isLtUnsigned;
                default: BrIllegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            NextPCSrc_q <= 1'b0;
        end else begin
            NextPCSrc_q <= NextPCSrc;
        end
    end

`ifdef BRANCH_STATS_EN
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            BrCount    <= '0;
            TakenCount <= '0;
        end else begin
            if (isCondBranch && !BrIllegal && (BrCount != '1)) begin
                BrCount <= BrCount + CNT_W'(1);
            end
            if (NextPCSrc && (TakenCount != '1)) begin
                TakenCount <= TakenCount + CNT_W'(1);
            end
        end
    end
`else
    logic unusedCond;
    assign unusedCond = isCondBranch;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed literal vectors, reset/counter
// sequence and randomized stimulus compared against an arithmetic reference model.
module tb_branch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4:0]      BrOp = 5'd0;
    logic [XLEN-1:0] A = '0;
    logic [XLEN-1:0] B = '0;
    logic            NextPCSrc;
    logic            BrIllegal;
    logic            NextPCSrc_q;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] BrCount;
    logic [CNT_W-1:0] TakenCount;
`endif

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // Reference state
    logic expQ = 1'b0;
    int   expBr = 0;
    int   expTaken = 0;

    branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BrOp       (BrOp),
        .A          (A),
        .B          (B),
        .NextPCSrc  (NextPCSrc),
        .BrIllegal  (BrIllegal),
        .NextPCSrc_q(NextPCSrc_q)
`ifdef BRANCH_STATS_EN
        ,
        .BrCount    (BrCount),
        .TakenCount (TakenCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Returns {taken, illegal} from the ISA rules using plain integer arithmetic.
    function automatic logic [1:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb;
        int code;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        code = int'(op);
        if (code >= 16) return 2'b10;
        if (code < 8)   return 2'b00;
        case (code - 8)
            0: return {ua == ub, 1'b0};
            1: return {ua != ub, 1'b0};
            4: return {sa < sb, 1'b0};
            5: return {sa >= sb, 1'b0};
            6: return {ua < ub, 1'b0};
            7: return {ua >= ub, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [1:0] r;
        r = refModel(BrOp, A, B);
        if (!rst_n) begin
            expQ     <= 1'b0;
            expBr    <= 0;
            expTaken <= 0;
        end else begin
            expQ <= r[1];
            if (BrOp[4:3] == 2'b01 && !r[0] && expBr < CNT_MAX) expBr <= expBr + 1;
            if (r[1] && expTaken < CNT_MAX) expTaken <= expTaken + 1;
        end
    end

    always @(negedge clk) begin
        logic [1:0] r;
        if (checkEn) begin
            r = refModel(BrOp, A, B);
            check("NextPCSrc", 64'(NextPCSrc), 64'(r[1]));
            check("BrIllegal", 64'(BrIllegal), 64'(r[0]));
            check("NextPCSrc_q", 64'(NextPCSrc_q), 64'(expQ));
`ifdef BRANCH_STATS_EN
            check("BrCount", 64'(BrCount), 64'(expBr));
            check("TakenCount", 64'(TakenCount), 64'(expTaken));
`endif
        end
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic applyVec(input vec_t v, input string name);
        @(posedge clk);
        #1;
        BrOp = v.op;
        A    = v.a;
        B    = v.b;
        #1;
        check({name, ".taken"}, 64'(NextPCSrc), 64'(v.taken));
        check({name, ".illegal"}, 64'(BrIllegal), 64'(v.ill));
    endtask

    initial begin
        vecs.push_back('{5'b10000, 32'h10, 32'h20, 1'b1, 1'b0});
        vecs.push_back('{5'b01000, 32'h5, 32'h5, 1'b1, 1'b0});
        vecs.push_back('{5'b01000, 32'h5, 32'h10, 1'b0, 1'b0});
        vecs.push_back('{5'b01001, 32'h5, 32'h10, 1'b1, 1'b0});
        vecs.push_back('{5'b01100, 32'h5, 32'hA, 1'b1, 1'b0});
        vecs.push_back('{5'b01100, 32'hFFFFFFFE, 32'h1, 1'b1, 1'b0});
        vecs.push_back('{5'b01101, 32'hA, 32'h5, 1'b1, 1'b0});
        vecs.push_back('{5'b01110, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0});
        vecs.push_back('{5'b01110, 32'h5, 32'hA, 1'b1, 1'b0});
        vecs.push_back('{5'b01111, 32'hA, 32'h5, 1'b1, 1'b0});
        vecs.push_back('{5'b01111, 32'h7, 32'h7, 1'b1, 1'b0});
        vecs.push_back('{5'b00000, 32'h1, 32'h2, 1'b0, 1'b0});
        vecs.push_back('{5'b01010, 32'h3, 32'h3, 1'b0, 1'b1});
        vecs.push_back('{5'b01011, 32'h3, 32'h9, 1'b0, 1'b1});
        vecs.push_back('{5'b01100, 32'h9, 32'h9, 1'b0, 1'b0});
        vecs.push_back('{5'b01101, 32'h9, 32'h9, 1'b1, 1'b0});
        vecs.push_back('{5'b01100, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{5'b01110, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{5'b11111, 32'h1, 32'h1, 1'b1, 1'b0});

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.q", 64'(NextPCSrc_q), 64'd0);
        rst_n = 1'b1;
        checkEn = 1'b1;

        applyVec(vecs[0], "jal");
        @(posedge clk);
        #1;
        check("jal.q_after_edge", 64'(NextPCSrc_q), 64'd1);
        for (int i = 1; i < vecs.size(); i++) applyVec(vecs[i], $sformatf("vec%0d", i));

        // Reset for one edge with a jump presented, then 3 taken BEQ and 1 not-taken BNE.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        BrOp = 5'b10000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset.q", 64'(NextPCSrc_q), 64'd0);
        check("midreset.comb", 64'(NextPCSrc), 64'd1);
        for (int i = 0; i < 3; i++) begin
            BrOp = 5'b01000;
            A = 32'(i + 3);
            B = 32'(i + 3);
            @(posedge clk);
            #1;
        end
        BrOp = 5'b01001;
        A = 32'h44;
        B = 32'h44;
        @(posedge clk);
        #1;
        BrOp = 5'b00000;
`ifdef BRANCH_STATS_EN
        check("stats.BrCount", 64'(BrCount), 64'd4);
        check("stats.TakenCount", 64'(TakenCount), 64'd3);
        BrOp = 5'b01000;
        A = 32'h1;
        B = 32'h1;
        repeat (CNT_MAX + 5) @(posedge clk);
        #1;
        check("sat.BrCount", 64'(BrCount), 64'(CNT_MAX));
        check("sat.TakenCount", 64'(TakenCount), 64'(CNT_MAX));
        BrOp = 5'b00000;
`endif

        // Randomized phase with boundary-biased operands and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pool[6];
            pool[0] = 32'h0;
            pool[1] = 32'hFFFFFFFF;
            pool[2] = 32'h80000000;
            pool[3] = 32'h7FFFFFFF;
            pool[4] = 32'hFFFFFFFE;
            pool[5] = 32'h1;
            @(posedge clk);
            #1;
            BrOp  = 5'($urandom_range(31, 0));
            if ($urandom_range(3, 0) == 0) BrOp = {2'b01, 3'($urandom_range(7, 0))};
            A     = ($urandom_range(2, 0) == 0) ? pool[$urandom_range(5, 0)] : $urandom;
            case ($urandom_range(3, 0))
                0:       B = A;
                1:       B = pool[$urandom_range(5, 0)];
                default: B = $urandom;
            endcase
            rst_n = ($urandom_range(19, 0) != 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
